noc_link_vc_arbiter: RTL

Packet-atomic arbiter that shares one router input link among several local requesters, such as a compute tile's network adapter, DMA and a debug bridge. Per virtual channel, it grants one requester with round-robin fairness and holds that grant until the packet's last flit. Across virtual channels, it interleaves flits onto the single physical link, one flit per cycle. It sits between the local sources and one `in_*` port of `noc_router`.

---
 rtl/noc_link_vc_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/noc_link_vc_arbiter.sv
// Packet-atomic link arbiter: round-robin requester grant per VC with a lock held until
// the last flit, and round-robin flit interleaving across VCs onto one physical link.
module noc_link_vc_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int VCHANNELS  = 2,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [REQUESTERS-1:0][FLIT_WIDTH-1:0]   req_flit,
  input  logic [REQUESTERS-1:0]                   req_last,
  input  logic [REQUESTERS-1:0][VCHANNELS-1:0]    req_valid,
  output logic [REQUESTERS-1:0][VCHANNELS-1:0]    req_ready,
  output logic [FLIT_WIDTH-1:0]                   out_flit,
  output logic                                    out_last,
  output logic [VCHANNELS-1:0]                    out_valid,
  input  logic [VCHANNELS-1:0]                    out_ready
);

  localparam int RW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  typedef logic [RW-1:0] req_idx_t;
  typedef logic [VW-1:0] vc_idx_t;

  function automatic req_idx_t req_wrap(input req_idx_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQUESTERS) s = s - REQUESTERS;
    return req_idx_t'(s);
  endfunction

  function automatic vc_idx_t vc_wrap(input vc_idx_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= VCHANNELS) s = s - VCHANNELS;
    return vc_idx_t'(s);
  endfunction

  req_idx_t [VCHANNELS-1:0] rr_ptr_q, rr_ptr_d;
  req_idx_t [VCHANNELS-1:0] owner_q, owner_d;
  logic     [VCHANNELS-1:0] locked_q, locked_d;
  vc_idx_t                  vc_ptr_q, vc_ptr_d;
  vc_idx_t                  hold_vc_q, hold_vc_d;
  logic                     hold_q, hold_d;

  req_idx_t [VCHANNELS-1:0] cand_idx;
  logic     [VCHANNELS-1:0] cand_valid;
  vc_idx_t                  sel;
  logic                     sel_valid;
  req_idx_t                 sel_req;
  logic                     xfer;

  // Per-VC candidate. The search runs from the farthest offset down so that the
  // nearest valid requester to rr_ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cand_idx   = '0;
    cand_valid = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      if (locked_q[v]) begin
        cand_idx[v]   = owner_q[v];
        cand_valid[v] = req_valid[owner_q[v]][v];
      end else begin
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
          if (req_valid[req_wrap(rr_ptr_q[v], k)][v]) begin
            cand_valid[v] = 1'b1;
            cand_idx[v]   = req_wrap(rr_ptr_q[v], k);
          end
        end
      end
    end
  end

  // VC select; out_ready is deliberately absent so out_valid never depends on it.
  always_comb begin
    sel       = hold_vc_q;
    sel_valid = 1'b0;
    if (hold_q) begin
      sel_valid = cand_valid[hold_vc_q];
    end else begin
      for (int k = VCHANNELS - 1; k >= 0; k--) begin
        if (cand_valid[vc_wrap(vc_ptr_q, k)]) begin
          sel_valid = 1'b1;
          sel       = vc_wrap(vc_ptr_q, k);
        end
      end
    end
    if (rst) sel_valid = 1'b0;
  end

  assign sel_req = cand_idx[sel];
  assign xfer    = sel_valid & out_ready[sel];

  always_comb begin
    out_valid = '0;
    out_flit  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    if (sel_valid) begin
      out_valid[sel]          = 1'b1;
      out_flit                = req_flit[sel_req];
      out_last                = req_last[sel_req];
      req_ready[sel_req][sel] = out_ready[sel];
    end
  end

  // A held flit that loses its candidate (protocol violation) simply drops the hold.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    locked_d  = locked_q;
    vc_ptr_d  = vc_ptr_q;
    hold_vc_d = hold_vc_q;
    hold_d    = 1'b0;
    if (xfer) begin
      if (out_last) begin
        locked_d[sel] = 1'b0;
        rr_ptr_d[sel] = req_wrap(sel_req, 1);
      end else begin
        locked_d[sel] = 1'b1;
        owner_d[sel]  = sel_req;
      end
      vc_ptr_d = vc_wrap(sel, 1);
    end else if (sel_valid) begin
      hold_d    = 1'b1;
      hold_vc_d = sel;
    end
  end

  // NOTE: the per-VC arrays are a handful of flops, not a RAM, so they are reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      locked_q  <= '0;
      vc_ptr_q  <= '0;
      hold_vc_q <= '0;
      hold_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      vc_ptr_q  <= vc_ptr_d;
      hold_vc_q <= hold_vc_d;
      hold_q    <= hold_d;
    end
  end

endmodule
